// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator: default sizing, FSM states, width helper.
package mac_pkg;

   localparam int unsigned DEF_N     = 8;
   localparam int unsigned DEF_G     = 8;
   localparam int unsigned DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } mac_state_e;

   function automatic int unsigned acc_width(input int unsigned n, input int unsigned g);
      return 2 * n + g;
   endfunction

endpackage

// File: rtl/mac_acc_add.sv
// Combinational extend-and-add stage with signed overflow / unsigned carry detection.
module mac_acc_add #(
   parameter int unsigned N     = 8,
   parameter int unsigned ACC_W = 24
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [2*N-1:0]   p,
   input  logic             mode_signed,
   output logic [ACC_W-1:0] ext_c,
   output logic [ACC_W-1:0] sum_c,
   output logic             ovf_c
);

   logic [ACC_W:0] full;

   always_comb begin
      ext_c = {{(ACC_W-2*N){p[2*N-1] & mode_signed}}, p};
      full  = {1'b0, acc} + {1'b0, ext_c};
      sum_c = full[ACC_W-1:0];
      // Signed: like-signed operands whose sum flips sign; unsigned: carry out.
      if (mode_signed)
         ovf_c = (acc[ACC_W-1] == ext_c[ACC_W-1]) && (sum_c[ACC_W-1] != acc[ACC_W-1]);
      else
         ovf_c = full[ACC_W];
   end

endmodule

// File: rtl/mac_accumulator.sv
// Burst accumulator for multiplier products: sums beats until in_last or a full
// count, then holds the result with sticky overflow/mode/truncation flags.
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned G     = DEF_G,
   parameter int unsigned CNT_W = DEF_CNT_W,
   localparam int unsigned ACC_W = acc_width(N, G)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-1:0]   in_p,
   input  logic             in_signed,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             out_mode_err,
   output logic             out_trunc
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   mac_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mode_q, mode_d;
   logic             ovf_q, ovf_d;
   logic             merr_q, merr_d;
   logic             trunc_q, trunc_d;
   logic             in_ready_q, out_valid_q;

   logic             accept;
   logic             add_mode;
   logic [ACC_W-1:0] ext_c, sum_c;
   logic             ovf_c;

   assign accept   = in_valid && in_ready_q && !clr;
   // First beat of a burst defines the mode; later beats use the latched one.
   assign add_mode = (state_q == ST_IDLE) ? in_signed : mode_q;

   mac_acc_add #(
      .N     (N),
      .ACC_W (ACC_W)
   ) u_add (
      .acc         (acc_q),
      .p           (in_p),
      .mode_signed (add_mode),
      .ext_c       (ext_c),
      .sum_c       (sum_c),
      .ovf_c       (ovf_c)
   );

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      mode_d  = mode_q;
      ovf_d   = ovf_q;
      merr_d  = merr_q;
      trunc_d = trunc_q;

      if (clr) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  acc_d   = ext_c;
                  count_d = CNT_W'(1);
                  mode_d  = in_signed;
                  ovf_d   = 1'b0;
                  merr_d  = 1'b0;
                  trunc_d = 1'b0;
                  state_d = ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  acc_d   = sum_c;
                  count_d = count_q + CNT_W'(1);
                  ovf_d   = ovf_q | ovf_c;
                  merr_d  = merr_q | (in_signed != mode_q);
               end
            end
            ST_HOLD: begin
               if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase

         if (accept && (in_last || count_d == CNT_MAX)) begin
            state_d = ST_HOLD;
            trunc_d = (count_d == CNT_MAX);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         mode_q      <= 1'b0;
         ovf_q       <= 1'b0;
         merr_q      <= 1'b0;
         trunc_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         mode_q      <= mode_d;
         ovf_q       <= ovf_d;
         merr_q      <= merr_d;
         trunc_q     <= trunc_d;
         in_ready_q  <= (state_d != ST_HOLD);
         out_valid_q <= (state_d == ST_HOLD);
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_acc      = acc_q;
   assign out_count    = count_q;
   assign out_ovf      = ovf_q;
   assign out_mode_err = merr_q;
   assign out_trunc    = trunc_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: default instance (A) and a narrow G=1, CNT_W=2 instance (B).
module tb_mac_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_signed = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   logic        sel_b = 1'b0;
   logic [15:0] in_p = '0;

   always #5 clk = ~clk;

   logic        in_valid_a, in_ready_a, valid_a, ovf_a, merr_a, trunc_a;
   logic [23:0] acc_a;
   logic [7:0]  cnt_a;
   logic        in_valid_b, in_ready_b, valid_b, ovf_b, merr_b, trunc_b;
   logic [16:0] acc_b;
   logic [1:0]  cnt_b;

   assign in_valid_a = in_valid & ~sel_b;
   assign in_valid_b = in_valid &  sel_b;

   mac_accumulator dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_p(in_p),
      .in_signed(in_signed), .in_last(in_last),
      .out_valid(valid_a), .out_ready(out_ready), .out_acc(acc_a),
      .out_count(cnt_a), .out_ovf(ovf_a), .out_mode_err(merr_a), .out_trunc(trunc_a)
   );

   mac_accumulator #(.N(8), .G(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_p(in_p),
      .in_signed(in_signed), .in_last(in_last),
      .out_valid(valid_b), .out_ready(out_ready), .out_acc(acc_b),
      .out_count(cnt_b), .out_ovf(ovf_b), .out_mode_err(merr_b), .out_trunc(trunc_b)
   );

   logic        o_rdy, o_valid, o_ovf, o_merr, o_trunc;
   logic [23:0] o_acc;
   logic [7:0]  o_cnt;

   always_comb begin
      o_rdy   = sel_b ? in_ready_b : in_ready_a;
      o_valid = sel_b ? valid_b : valid_a;
      o_acc   = sel_b ? 24'(acc_b) : acc_a;
      o_cnt   = sel_b ? 8'(cnt_b) : cnt_a;
      o_ovf   = sel_b ? ovf_b : ovf_a;
      o_merr  = sel_b ? merr_b : merr_a;
      o_trunc = sel_b ? trunc_b : trunc_a;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit              use_b;
      int unsigned     nb;
      logic [2:0][15:0] p;
      logic [2:0]      sgn;
      bit              last;
      logic [23:0]     e_acc;
      logic [7:0]      e_cnt;
      logic            e_ovf;
      logic            e_merr;
      logic            e_trunc;
   } vec_t;

   function automatic vec_t mk(input bit b, input int unsigned nb,
                               input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                               input logic [2:0] sgn, input bit last, input logic [23:0] acc,
                               input logic [7:0] cnt, input logic ovf, input logic merr,
                               input logic trunc);
      vec_t v;
      v.use_b = b;   v.nb = nb;
      v.p[0] = p0;   v.p[1] = p1;   v.p[2] = p2;
      v.sgn = sgn;   v.last = last;
      v.e_acc = acc; v.e_cnt = cnt;
      v.e_ovf = ovf; v.e_merr = merr; v.e_trunc = trunc;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] p, input logic s, input logic last);
      in_valid = 1'b1; in_p = p; in_signed = s; in_last = last;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_valid_fall"}, 32'(o_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(o_rdy), 32'd1);
   endtask

   vec_t vecs[8];

   initial begin
      // sgn bit i is the in_signed of beat i
      vecs[0] = mk(0, 3, 16'h00FF, 16'h0001, 16'h0100, 3'b000, 1, 24'h000200, 8'd3, 0, 0, 0);
      vecs[1] = mk(0, 2, 16'hFF80, 16'h0040, 16'h0000, 3'b011, 1, 24'hFFFFC0, 8'd2, 0, 0, 0);
      vecs[2] = mk(1, 3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'b000, 1, 24'h00FFFD, 8'd3, 1, 0, 1);
      vecs[3] = mk(0, 2, 16'h0001, 16'hFFFF, 16'h0000, 3'b001, 1, 24'h000000, 8'd2, 0, 1, 0);
      vecs[4] = mk(0, 1, 16'h8000, 16'h0000, 16'h0000, 3'b001, 1, 24'hFF8000, 8'd1, 0, 0, 0);
      vecs[5] = mk(0, 1, 16'h8000, 16'h0000, 16'h0000, 3'b000, 1, 24'h008000, 8'd1, 0, 0, 0);
      vecs[6] = mk(1, 3, 16'h0001, 16'h0001, 16'h0001, 3'b000, 0, 24'h000003, 8'd3, 0, 0, 1);
      vecs[7] = mk(1, 3, 16'h7FFF, 16'h7FFF, 16'h7FFF, 3'b111, 1, 24'h017FFD, 8'd3, 1, 0, 1);

      // Reset state while rst_n is low
      #12;
      chk("rst_ready_a", 32'(in_ready_a), 32'd1);
      chk("rst_valid_a", 32'(valid_a), 32'd0);
      chk("rst_acc_a", 32'(acc_a), 32'd0);
      chk("rst_cnt_a", 32'(cnt_a), 32'd0);
      chk("rst_flags_a", {29'd0, ovf_a, merr_a, trunc_a}, 32'd0);
      chk("rst_ready_b", 32'(in_ready_b), 32'd1);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         sel_b = vecs[i].use_b;
         for (int k = 0; k < int'(vecs[i].nb); k++)
            beat(vecs[i].p[k], vecs[i].sgn[k], (k == int'(vecs[i].nb) - 1) && vecs[i].last);
         chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'd1);
         chk($sformatf("v%0d_ready", i), 32'(o_rdy), 32'd0);
         chk($sformatf("v%0d_acc", i), 32'(o_acc), 32'(vecs[i].e_acc));
         chk($sformatf("v%0d_cnt", i), 32'(o_cnt), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d_ovf", i), 32'(o_ovf), 32'(vecs[i].e_ovf));
         chk($sformatf("v%0d_merr", i), 32'(o_merr), 32'(vecs[i].e_merr));
         chk($sformatf("v%0d_trunc", i), 32'(o_trunc), 32'(vecs[i].e_trunc));
         release_result($sformatf("v%0d", i));
      end
      sel_b = 1'b0;

      // Backpressure: result held 5 cycles while a beat is offered
      beat(16'h0005, 1'b0, 1'b0);
      beat(16'h0003, 1'b0, 1'b1);
      in_valid = 1'b1; in_p = 16'h00AA;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("hold%0d_valid", c), 32'(valid_a), 32'd1);
         chk($sformatf("hold%0d_acc", c), 32'(acc_a), 32'h8);
         chk($sformatf("hold%0d_cnt", c), 32'(cnt_a), 32'd2);
         chk($sformatf("hold%0d_ready", c), 32'(in_ready_a), 32'd0);
         tick();
      end
      in_valid = 1'b0;
      release_result("hold");

      // Reset asserted mid-burst
      beat(16'h0011, 1'b0, 1'b0);
      beat(16'h0022, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("mrst_valid", 32'(valid_a), 32'd0);
      chk("mrst_ready", 32'(in_ready_a), 32'd1);
      chk("mrst_cnt", 32'(cnt_a), 32'd0);
      chk("mrst_acc", 32'(acc_a), 32'd0);
      #2 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("mrst_quiet%0d", c), 32'(valid_a), 32'd0);
      end
      beat(16'h0007, 1'b0, 1'b1);
      chk("mrst_new_valid", 32'(valid_a), 32'd1);
      chk("mrst_new_cnt", 32'(cnt_a), 32'd1);
      chk("mrst_new_acc", 32'(acc_a), 32'h7);
      release_result("mrst");

      // clr mid-burst, with a last beat offered in the same cycle
      beat(16'h0100, 1'b0, 1'b0);
      beat(16'h0200, 1'b0, 1'b0);
      clr = 1'b1;
      beat(16'h0300, 1'b0, 1'b1);
      clr = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("clr_quiet%0d", c), 32'(valid_a), 32'd0);
         chk($sformatf("clr_ready%0d", c), 32'(in_ready_a), 32'd1);
         tick();
      end
      beat(16'h0009, 1'b0, 1'b1);
      chk("clr_new_cnt", 32'(cnt_a), 32'd1);
      chk("clr_new_acc", 32'(acc_a), 32'h9);

      // clr while holding a result drops it
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_hold_valid", 32'(valid_a), 32'd0);
      chk("clr_hold_ready", 32'(in_ready_a), 32'd1);
      tick();
      chk("clr_hold_quiet", 32'(valid_a), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
